// File: rtl/vocoder_pkg.sv
// Shared types and config words for the FFT feeder path.
// Config word: bit0=1 selects a forward transform, bit0=0 an inverse transform.
package vocoder_pkg;

  localparam int CFG_W = 16;
  localparam logic [CFG_W-1:0] CFG_FWD = 16'h0001;
  localparam logic [CFG_W-1:0] CFG_INV = 16'h0000;

  localparam int SAMPLE_W = 24;

  typedef enum logic {
    S_CFG = 1'b0,
    S_RUN = 1'b1
  } feeder_state_t;

  // One word on the transform data bus: imaginary part in the upper half.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] im;
    logic signed [SAMPLE_W-1:0] re;
  } cplx_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sync FIFO: the head is readable combinationally; a push to an empty FIFO shows up next cycle.
// A push into a full FIFO is taken only when a pop happens in the same cycle, otherwise the caller must drop it.
module sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             wrEn;
  logic             rdEn;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  // When full, the slot being written is the one being read, so the pop frees it.
  assign wrEn = push && (!full || pop);
  assign rdEn = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Feeds buffered real samples to the FFT core after a one-shot config word, adding tlast every FRAME_LEN points.
// One cycle from sample to tvalid; data stalls under tready=0 while the source keeps pushing and overflow drops are flagged.
module fft_frame_feeder
  import vocoder_pkg::*;
#(
  parameter int                   DATAWIDTH  = $bits(cplx_t),
  parameter int                   FRAME_LEN  = 1024,
  parameter int                   FIFO_DEPTH = 16,
  parameter int                   CFG_WIDTH  = CFG_W,
  parameter logic [CFG_WIDTH-1:0] CFG_WORD   = CFG_FWD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATAWIDTH/2-1:0] sample_in,
  input  logic                   sample_valid,
  output logic [CFG_WIDTH-1:0]   cfg_tdata,
  output logic                   cfg_tvalid,
  input  logic                   cfg_tready,
  output logic [DATAWIDTH-1:0]   fft_tdata,
  output logic                   fft_tvalid,
  input  logic                   fft_tready,
  output logic                   fft_tlast,
  input  logic                   tlast_err_in,
  output logic                   overflow,
  output logic                   frame_err,
  output logic [15:0]            frames_sent
);

  localparam int HALF  = DATAWIDTH / 2;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  feeder_state_t   state;
  feeder_state_t   nextState;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [HALF-1:0] fifoHead;
  logic [IDX_W-1:0] frameIdx;
  logic            dataHs;
  logic            dropSample;

  sample_fifo #(
    .WIDTH (HALF),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (sample_valid),
    .pushData (sample_in),
    .pop      (dataHs),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (fifoHead)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CFG;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (state == S_CFG && cfg_tready) nextState = S_RUN;
  end

  // tvalid must read low while reset is held even though the reset state is S_CFG.
  always_comb begin
    cfg_tvalid = rst_n && (state == S_CFG);
    cfg_tdata  = CFG_WORD;
    fft_tvalid = (state == S_RUN) && !fifoEmpty;
  end

  assign fft_tdata  = {{(DATAWIDTH-HALF){1'b0}}, fifoHead};
  assign fft_tlast  = fft_tvalid && (frameIdx == LAST_IDX);
  assign dataHs     = fft_tvalid && fft_tready;
  assign dropSample = sample_valid && fifoFull && !dataHs;

  // FRAME_LEN is a power of two, so the index wraps to zero on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameIdx    <= '0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (dataHs)             frameIdx    <= frameIdx + 1'b1;
      if (dataHs && fft_tlast) frames_sent <= frames_sent + 16'd1;
      if (dropSample)         overflow    <= 1'b1;
      if (tlast_err_in)       frame_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomised and directed checks of fft_frame_feeder against a queue-based model of the sample stream.
module tb_fft_frame_feeder;

  localparam int DW    = 48;
  localparam int HW    = 24;
  localparam int FL    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] sample_in;
  logic          sample_valid;
  logic [15:0]   cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [DW-1:0] fft_tdata;
  logic          fft_tvalid;
  logic          fft_tready;
  logic          fft_tlast;
  logic          tlast_err_in;
  logic          overflow;
  logic          frame_err;
  logic [15:0]   frames_sent;

  fft_frame_feeder #(
    .DATAWIDTH  (DW),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (DEPTH),
    .CFG_WIDTH  (16),
    .CFG_WORD   (16'h0001)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .cfg_tdata    (cfg_tdata),
    .cfg_tvalid   (cfg_tvalid),
    .cfg_tready   (cfg_tready),
    .fft_tdata    (fft_tdata),
    .fft_tvalid   (fft_tvalid),
    .fft_tready   (fft_tready),
    .fft_tlast    (fft_tlast),
    .tlast_err_in (tlast_err_in),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: configured flag, queue of buffered samples, total accepted handshakes.
  bit            mCfgDone;
  logic [HW-1:0] mQ[$];
  int            mSent;
  bit            mOvf;
  bit            mErr;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mCfgDone = 0;
        mQ.delete();
        mSent = 0;
        mOvf  = 0;
        mErr  = 0;
      end else begin
        if (mCfgDone && mQ.size() > 0 && fft_tready) begin
          void'(mQ.pop_front());
          mSent++;
        end
        if (sample_valid) begin
          if (mQ.size() < DEPTH) mQ.push_back(sample_in);
          else                   mOvf = 1;
        end
        if (tlast_err_in) mErr = 1;
        if (!mCfgDone && cfg_tready) mCfgDone = 1;
      end
    end
  end

  // Compare process: outputs are settled mid-cycle, one negedge before the edge that consumes them.
  logic [HW-1:0] hsData[$];
  bit            hsLast[$];
  int            cfgHi;
  bit            prevStall;
  logic [DW-1:0] prevData;
  logic          prevLast;
  bit            expTv;

  initial begin
    prevStall = 0;
    cfgHi     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStall = 0;
      end else begin
        expTv = mCfgDone && (mQ.size() > 0);
        chk("cfg_tvalid", cfg_tvalid, !mCfgDone);
        if (!mCfgDone) chk("cfg_tdata", cfg_tdata, 16'h0001);
        chk("fft_tvalid", fft_tvalid, expTv);
        if (expTv) begin
          chk("fft_tdata", fft_tdata, {24'h0, mQ[0]});
          chk("fft_tlast", fft_tlast, (mSent % FL) == FL - 1);
        end
        chk("overflow", overflow, mOvf);
        chk("frame_err", frame_err, mErr);
        chk("frames_sent", frames_sent, (mSent / FL) % 65536);
        if (prevStall) begin
          chk("stall_tvalid", fft_tvalid, 1'b1);
          chk("stall_tdata", fft_tdata, prevData);
          chk("stall_tlast", fft_tlast, prevLast);
        end
        prevStall = fft_tvalid && !fft_tready;
        prevData  = fft_tdata;
        prevLast  = fft_tlast;
        if (fft_tvalid && fft_tready) begin
          hsData.push_back(fft_tdata[HW-1:0]);
          hsLast.push_back(fft_tlast);
        end
        if (cfg_tvalid) cfgHi++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushS(input logic [HW-1:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    fft_tready   = 1'b1;
    sample_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chkSeq(input string nm, input int base, input int n);
    chk({nm, "_count"}, hsData.size(), n);
    for (int i = 0; i < n && i < hsData.size(); i++)
      chk({nm, "_data"}, hsData[i], base + i);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    cfg_tready   = 1'b0;
    fft_tready   = 1'b0;
    tlast_err_in = 1'b0;

    #12;
    chk("rst_cfg_tvalid", cfg_tvalid, 0);
    chk("rst_fft_tvalid", fft_tvalid, 0);
    chk("rst_fft_tlast", fft_tlast, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frames_sent", frames_sent, 0);

    // Config handshake held off for five cycles.
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfgHi = 0;
    repeat (5) tick();
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    tick();
    chk("cfg_high_cycles", cfgHi, 6);

    // Two back-to-back frames of 1..16.
    hsData.delete(); hsLast.delete();
    fft_tready = 1'b1;
    for (int i = 1; i <= 16; i++) pushS(HW'(i));
    drain(4);
    chkSeq("frames2", 1, 16);
    for (int i = 0; i < 16 && i < hsLast.size(); i++)
      chk("frames2_tlast", hsLast[i], (i == 7 || i == 15));
    chk("frames2_sent", frames_sent, 2);

    // Toggling tready while samples arrive every cycle.
    hsData.delete(); hsLast.delete();
    for (int c = 0; c < 24; c++) begin
      fft_tready   = c[0];
      sample_valid = (c < 8);
      sample_in    = HW'(100 + c);
      tick();
    end
    drain(10);
    chkSeq("toggle", 100, 8);

    // Full FIFO with simultaneous push and pop.
    hsData.delete(); hsLast.delete();
    fft_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) pushS(HW'(300 + i));
    chk("full_tvalid", fft_tvalid, 1);
    fft_tready   = 1'b1;
    sample_valid = 1'b1;
    sample_in    = HW'(316);
    tick();
    sample_valid = 1'b0;
    fft_tready   = 1'b0;
    tick();
    chk("pushpop_overflow", overflow, 0);
    drain(24);
    chkSeq("pushpop", 300, 17);

    // Overflow: three samples beyond capacity are dropped.
    hsData.delete(); hsLast.delete();
    fft_tready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) pushS(HW'(400 + i));
    tick();
    chk("ovf_set", overflow, 1);
    drain(24);
    chkSeq("ovf", 400, 16);
    chk("ovf_sticky", overflow, 1);

    // Bring the frame index to 5 (61 handshakes so far), then reset mid-frame.
    for (int i = 0; i < 4; i++) pushS(HW'(450 + i));
    drain(4);
    fft_tready = 1'b0;
    for (int i = 0; i < 3; i++) pushS(HW'(460 + i));
    chk("pre_rst_tvalid", fft_tvalid, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fft_tvalid", fft_tvalid, 0);
    chk("arst_cfg_tvalid", cfg_tvalid, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_frames_sent", frames_sent, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat ($urandom_range(0, 3)) tick();
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    hsData.delete(); hsLast.delete();
    fft_tready = 1'b1;
    for (int i = 0; i < 10; i++) pushS(HW'(500 + i));
    drain(6);
    chkSeq("postrst", 500, 10);
    for (int i = 0; i < 10 && i < hsLast.size(); i++)
      chk("postrst_tlast", hsLast[i], i == 7);
    chk("postrst_frames", frames_sent, 1);

    tlast_err_in = 1'b1;
    tick();
    tlast_err_in = 1'b0;
    chk("frame_err_set", frame_err, 1);

    // Random traffic under random backpressure.
    for (int c = 0; c < 800; c++) begin
      sample_valid = ($urandom_range(0, 9) < 6);
      sample_in    = HW'($urandom);
      fft_tready   = $urandom_range(0, 1) == 1;
      tick();
    end
    drain(24);
    chk("final_empty", fft_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
